tm_trainer: RTL and testbench

TM_TRAINER -- requirements
Module: tm_trainer

---
 rtl/tm_trainer.sv | 161 ++++++++++++++++
 tb/tb_tm_trainer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tm_trainer.sv
// Tsetlin Machine trainer: 8 clauses x 4 literals of 3-bit automata, updated one
// clause per cycle from a snapshot of clause outputs taken in the EVAL cycle.
module tm_trainer #(
    parameter logic [31:0] SEED  = 32'hACE1_2024,
    parameter logic [8:0]  S_INV = 9'd64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       train_valid,
    output logic       train_ready,
    input  logic [1:0] features,
    input  logic       target,
    output logic [3:0] exclude_state1,
    output logic [3:0] exclude_state2,
    output logic [3:0] exclude_state3,
    output logic [3:0] exclude_state4,
    output logic [3:0] exclude_state5,
    output logic [3:0] exclude_state6,
    output logic [3:0] exclude_state7,
    output logic [3:0] exclude_state8,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [7:0][3:0][2:0]  ta_q, ta_d;
    logic [7:0]            clause_q, clause_d;
    logic [1:0]            feat_q, feat_d;
    logic                  tgt_q, tgt_d;
    logic [2:0]            idx_q, idx_d;
    logic [31:0]           lfsr_q, lfsr_d;

    logic [3:0]            lit;
    logic                  upd_cls;
    logic                  upd_pos;
    logic                  upd_type1;

    // Literal order matches the exclude mask bits: x0, x1, ~x0, ~x1.
    assign lit       = {~feat_q[1], ~feat_q[0], feat_q[1], feat_q[0]};
    assign upd_cls   = idx_q[2];
    assign upd_pos   = ~idx_q[0];
    assign upd_type1 = (upd_cls == tgt_q) ? upd_pos : ~upd_pos;

    function automatic logic clause_eval(input logic [3:0][2:0] tas, input logic [3:0] l);
        logic out;
        out = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            if (tas[k][2] && !l[k]) out = 1'b0;
        end
        return out;
    endfunction

    function automatic logic [2:0] ta_next(input logic [2:0] ta, input logic type1,
                                           input logic cl, input logic lt,
                                           input logic hit_low);
        logic inc;
        logic dec;
        inc = 1'b0;
        dec = 1'b0;
        if (type1) begin
            if (cl && lt) inc = ~hit_low;
            else          dec = hit_low;
        end else begin
            inc = cl & ~lt & ~ta[2];
        end
        if (inc && ta != 3'd7)      return ta + 3'd1;
        else if (dec && ta != 3'd0) return ta - 3'd1;
        else                        return ta;
    endfunction

    function automatic logic [3:0] excl(input logic [3:0][2:0] tas);
        logic [3:0] m;
        for (int unsigned k = 0; k < 4; k++) m[k] = ~tas[k][2];
        return m;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (train_valid) state_d = S_EVAL;
            S_EVAL:   state_d = S_UPDATE;
            S_UPDATE: if (idx_q == 3'd7) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign train_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

    always_comb begin
        feat_d   = feat_q;
        tgt_d    = tgt_q;
        idx_d    = idx_q;
        clause_d = clause_q;
        lfsr_d   = lfsr_q;
        ta_d     = ta_q;
        case (state_q)
            S_IDLE: begin
                if (train_valid) begin
                    feat_d = features;
                    tgt_d  = target;
                    idx_d  = '0;
                end
            end
            S_EVAL: begin
                for (int unsigned c = 0; c < 8; c++) begin
                    clause_d[c] = clause_eval(ta_q[c], lit);
                end
            end
            S_UPDATE: begin
                // Galois LFSR, x^32 + x^22 + x^2 + x + 1; current value feeds this clause.
                lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : '0);
                idx_d  = idx_q + 3'd1;
                for (int unsigned k = 0; k < 4; k++) begin
                    ta_d[idx_q][k] = ta_next(ta_q[idx_q][k], upd_type1, clause_q[idx_q],
                                             lit[k], ({1'b0, lfsr_q[8*k +: 8]} < S_INV));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ta_q     <= {32{3'd3}};
            clause_q <= '0;
            feat_q   <= '0;
            tgt_q    <= 1'b0;
            idx_q    <= '0;
            lfsr_q   <= SEED;
        end else begin
            state_q  <= state_d;
            ta_q     <= ta_d;
            clause_q <= clause_d;
            feat_q   <= feat_d;
            tgt_q    <= tgt_d;
            idx_q    <= idx_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign exclude_state1 = excl(ta_q[0]);
    assign exclude_state2 = excl(ta_q[1]);
    assign exclude_state3 = excl(ta_q[2]);
    assign exclude_state4 = excl(ta_q[3]);
    assign exclude_state5 = excl(ta_q[4]);
    assign exclude_state6 = excl(ta_q[5]);
    assign exclude_state7 = excl(ta_q[6]);
    assign exclude_state8 = excl(ta_q[7]);

endmodule

// File: tb/tb_tm_trainer.sv
// Directed bench: two trainers (S_INV=0 always hits high, S_INV=256 always hits low)
// share stimulus so feedback outcomes are deterministic and hand-computable.
module tb_tm_trainer;

    logic       clk;
    logic       rst;
    logic       train_valid;
    logic [1:0] features;
    logic       target;

    logic            rdy0, busy0, done0;
    logic            rdy1, busy1, done1;
    logic [8:1][3:0] ex0;
    logic [8:1][3:0] ex1;

    int n_tests = 0;
    int n_fail  = 0;

    tm_trainer #(.S_INV(9'd0)) u_s0 (
        .clk(clk), .rst(rst), .train_valid(train_valid), .train_ready(rdy0),
        .features(features), .target(target),
        .exclude_state1(ex0[1]), .exclude_state2(ex0[2]), .exclude_state3(ex0[3]),
        .exclude_state4(ex0[4]), .exclude_state5(ex0[5]), .exclude_state6(ex0[6]),
        .exclude_state7(ex0[7]), .exclude_state8(ex0[8]),
        .busy(busy0), .done(done0)
    );

    tm_trainer #(.S_INV(9'd256)) u_s256 (
        .clk(clk), .rst(rst), .train_valid(train_valid), .train_ready(rdy1),
        .features(features), .target(target),
        .exclude_state1(ex1[1]), .exclude_state2(ex1[2]), .exclude_state3(ex1[3]),
        .exclude_state4(ex1[4]), .exclude_state5(ex1[5]), .exclude_state6(ex1[6]),
        .exclude_state7(ex1[7]), .exclude_state8(ex1[8]),
        .busy(busy1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // a* = expected mask of clauses 1,3,6,8; b* = clauses 2,4,5,7.
    task automatic check_masks(input string tag, input logic [3:0] a0, input logic [3:0] b0,
                               input logic [3:0] a1, input logic [3:0] b1);
        for (int c = 1; c <= 8; c++) begin
            bit grp_a;
            grp_a = (c == 1 || c == 3 || c == 6 || c == 8);
            check($sformatf("%s s0 clause%0d", tag, c), 32'(ex0[c]), 32'(grp_a ? a0 : b0));
            check($sformatf("%s s256 clause%0d", tag, c), 32'(ex1[c]), 32'(grp_a ? a1 : b1));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " status"}, 32'({rdy0, busy0, done0, rdy1, busy1, done1}), 32'(6'b100_100));
    endtask

    // Called at a negedge; the reset edge falls before the next negedge.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge with both DUTs idle; returns at negedge 11 after the accept edge.
    task automatic run_pass(input logic [1:0] f, input logic t, input string tag);
        features    = f;
        target      = t;
        train_valid = 1'b1;
        @(negedge clk);
        train_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            logic d;
            d = (k == 10);
            check($sformatf("%s cycle%0d", tag, k),
                  32'({rdy0, busy0, done0, rdy1, busy1, done1}),
                  32'({1'b0, 1'b1, d, 1'b0, 1'b1, d}));
            @(negedge clk);
        end
        check_idle({tag, " end"});
    endtask

    initial begin
        rst         = 1'b1;
        train_valid = 1'b0;
        features    = 2'b00;
        target      = 1'b0;
        @(negedge clk);
        do_reset();

        check_masks("reset", 4'hF, 4'hF, 4'hF, 4'hF);
        check_idle("reset");

        run_pass(2'b01, 1'b0, "t0pass");
        check_masks("t0pass", 4'b0110, 4'b1001, 4'b1111, 4'b1001);

        do_reset();
        run_pass(2'b01, 1'b1, "t1pass");
        check_masks("t1pass", 4'b1001, 4'b0110, 4'b1001, 4'b1111);

        do_reset();
        for (int p = 0; p < 10; p++) run_pass(2'b01, 1'b0, $sformatf("rep%0d", p));
        check_masks("rep10", 4'b0110, 4'b1001, 4'b1111, 4'b1001);

        // Valid held high while the inputs keep changing mid-pass.
        do_reset();
        features    = 2'b01;
        target      = 1'b0;
        train_valid = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            features = 2'(k + 1);
            target   = ~target;
            check($sformatf("hold cycle%0d", k), 32'({rdy0, done0}), 32'({1'b0, (k == 10)}));
            if (k == 10) check_masks("hold", 4'b0110, 4'b1001, 4'b1111, 4'b1001);
            @(negedge clk);
        end
        check("hold idle ready", 32'({rdy0, busy0}), 32'(2'b10));
        @(negedge clk);
        check("hold reaccept", 32'({rdy0, busy0}), 32'(2'b01));
        train_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_idle("hold second end");

        // Reset while UPDATE is working on clause 4.
        do_reset();
        features    = 2'b01;
        target      = 1'b0;
        train_valid = 1'b1;
        @(negedge clk);
        train_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst clause1 written", 32'(ex0[1]), 32'(4'b0110));
        check("midrst clause4 pending", 32'(ex0[4]), 32'(4'b1111));
        check("midrst busy", 32'(busy0), 32'(1'b1));
        do_reset();
        check_masks("midrst", 4'hF, 4'hF, 4'hF, 4'hF);
        check_idle("midrst");
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 12; k++) begin
                seen = seen | done0 | done1 | busy0;
                @(negedge clk);
            end
            check("midrst no done", 32'(seen), 32'(1'b0));
        end
        run_pass(2'b01, 1'b0, "after");
        check_masks("after", 4'b0110, 4'b1001, 4'b1111, 4'b1001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
